// File: rtl/uart_conv8to16_if.sv
// rtl/uart_conv8to16_if.sv - byte-in / tagged-word-out bundle for uart_conv8to16
interface uart_conv8to16_if;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [15:0] data;
  logic        conv8to16valid;
  logic [7:0]  err_cnt;

  modport master (
    output rx_data,
    output rx_done,
    input  data,
    input  conv8to16valid,
    input  err_cnt
  );

  modport slave (
    input  rx_data,
    input  rx_done,
    output data,
    output conv8to16valid,
    output err_cnt
  );
endinterface

// File: rtl/uart_conv8to16.sv
// rtl/uart_conv8to16.sv - pairs UART bytes into tagged 16-bit words, high byte first
module uart_conv8to16 #(
  parameter int unsigned TIMEOUT = 200000,
  parameter logic [3:0]  TAG_MIN = 4'h3,
  parameter logic [3:0]  TAG_MAX = 4'h7
) (
  input  logic               clk,
  input  logic               rst,
  uart_conv8to16_if.slave    bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_WAIT_LO = 2'b01;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    hold_q, hold_d;
  logic [15:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic [7:0]    err_q, err_d;
  logic          err_inc;
  logic          tag_ok;

  assign tag_ok = (bus.rx_data[7:4] >= TAG_MIN) && (bus.rx_data[7:4] <= TAG_MAX);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_done) begin
          if (tag_ok) begin
            hold_d  = bus.rx_data;
            timer_d = '0;
            state_d = ST_WAIT_LO;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      ST_WAIT_LO: begin
        // A byte arriving on the last allowed cycle still completes the word.
        if (bus.rx_done) begin
          data_d  = {hold_q, bus.rx_data};
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'h01 : err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      hold_q  <= 8'h00;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
      err_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.data           = data_q;
  assign bus.conv8to16valid = valid_q;
  assign bus.err_cnt        = err_q;

endmodule
